lut_mult_seq_ctrl: RTL

Multi-cycle sequencer and two-port arbiter for constant-coefficient LUT multiplication of wide operands. It accepts NBYTES-byte operands from two requesters and arbitrates between them round-robin. It feeds one byte per cycle through a single 8-bit × A_const partial-product stage, with a 16-bit product, and shift-accumulates the result. It sits between producer logic and consumers that need X·A_const for operands wider than 8 bits, so the design needs only one 8-bit constant multiplier core.

---
 rtl/lut_mult_seq_ctrl.sv | 139 +++++++++++++
 1 files changed

// File: rtl/lut_mult_seq_ctrl.sv
// Round-robin two-port sequencer that multiplies a wide operand by a constant
// one byte per cycle through a single 8-bit x A_const partial-product stage.
module lut_mult_seq_ctrl #(
  parameter int A_const = 2,
  parameter int NBYTES  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in0_valid,
  input  logic [8*NBYTES-1:0]   in0_x,
  output logic                  in0_ready,
  input  logic                  in1_valid,
  input  logic [8*NBYTES-1:0]   in1_x,
  output logic                  in1_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES+7:0]   out_c,
  output logic                  out_id,
  output logic                  busy
);

  localparam int W  = 8*NBYTES+8;
  localparam int XW = 8*NBYTES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_next_s;
  logic [XW-1:0]   opreg_r;
  logic [W-1:0]    acc_r;
  logic [2:0]      k_r;
  logic            cur_id_r;
  logic            last_id_r;

  logic            grant0_s;
  logic            grant1_s;
  logic            accept_s;
  logic            k_last_s;
  logic [7:0]      byte_s;
  logic [15:0]     pp_s;
  logic [W-1:0]    pp_ext_s;

  // On a tie the port that did not complete last wins, giving 0,1,0,1 fairness.
  assign grant0_s  = in0_valid & (~in1_valid | last_id_r);
  assign grant1_s  = in1_valid & (~in0_valid | ~last_id_r);
  assign in0_ready = (state_r == IDLE) & grant0_s & ~rst;
  assign in1_ready = (state_r == IDLE) & grant1_s & ~rst;
  assign accept_s  = in0_ready | in1_ready;

  assign k_last_s  = (k_r == 3'(NBYTES-1));
  assign byte_s    = 8'(opreg_r >> {k_r, 3'b000});
  assign pp_s      = {8'd0, byte_s} * 16'(A_const);
  assign pp_ext_s  = W'(pp_s) << {k_r, 3'b000};

  assign out_valid = (state_r == DONE);
  assign busy      = (state_r != IDLE);
  assign out_c     = acc_r;
  assign out_id    = cur_id_r;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state decode; MUL always runs the full NBYTES cycles, zero bytes included.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = MUL;
        end else begin
          state_next_s = IDLE;
        end
      end
      MUL: begin
        if (k_last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = MUL;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Operand capture, shift-accumulate and completion bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      opreg_r   <= '0;
      acc_r     <= '0;
      k_r       <= 3'd0;
      cur_id_r  <= 1'b0;
      last_id_r <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            opreg_r  <= in1_ready ? in1_x : in0_x;
            cur_id_r <= in1_ready;
            acc_r    <= '0;
            k_r      <= 3'd0;
          end
        end
        MUL: begin
          acc_r <= acc_r + pp_ext_s;
          if (!k_last_s) begin
            k_r <= k_r + 3'd1;
          end
        end
        DONE: begin
          // last_id moves only on completion so a stalled result keeps its turn.
          if (out_ready) begin
            last_id_r <= cur_id_r;
          end
        end
        default: begin
          k_r <= 3'd0;
        end
      endcase
    end
  end

endmodule
